// File: rtl/bpsk_symbol_serializer_pkg.sv
// bpsk_symbol_serializer_pkg: modem-wide symbol codes, state encoding and size limits
package bpsk_symbol_serializer_pkg;
  localparam logic [1:0] SYM_POS = 2'b01;
  localparam logic [1:0] SYM_NEG = 2'b11;
  localparam int N_MAX = 15;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/bpsk_symbol_serializer.sv
// bpsk_symbol_serializer: shifts a word of N two-bit BPSK symbols out one per handshake, LSB pair first
module bpsk_symbol_serializer
  import bpsk_symbol_serializer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*N-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [1:0]     out_sym,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           sym_err
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  // Both legal codes have bit 0 set; a pair with bit 0 clear is illegal
  localparam logic [2*N-1:0] LEGAL_MASK = {N{SYM_POS & SYM_NEG}};
  if (N < 1 || N > N_MAX) begin : g_bad_n
    $error("N out of range");
  end
  state_t state, nxt;
  logic [2*N-1:0] sreg;
  logic [IW-1:0] idx;
  logic last_idx, in_xfer, out_xfer;
  assign last_idx = idx == IW'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb nxt = in_xfer ? SEND : (out_xfer && last_idx) ? IDLE : state;
  always_comb begin
    out_valid = state == SEND;
    out_last = out_valid && last_idx;
    out_sym = out_valid ? sreg[1:0] : 2'b00;
    in_ready = !out_valid || (out_ready && last_idx);
    in_xfer = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sreg <= '0;
      idx <= '0;
      sym_err <= 1'b0;
    end else if (in_xfer) begin
      sreg <= in_data;
      idx <= '0;
      sym_err <= sym_err || ((in_data & LEGAL_MASK) != LEGAL_MASK);
    end else if (out_xfer && !last_idx) begin
      sreg <= sreg >> 2;
      idx <= idx + IW'(1);
    end
endmodule

// File: doc/bpsk_symbol_serializer.md
BPSK_SYMBOL_SERIALIZER -- requirements
Module: bpsk_symbol_serializer

Interface
REQ-001 SHALL have parameter N, default 8, giving the number of BPSK symbols per word; legal range 1..15 (8 for Hamming words, 15 for BCH words).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_data, input, 2N bits: modulator output word; pair k = in_data[2k+1:2k]; 2'b01 = +1, 2'b11 = -1.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 SHALL have port out_sym, output, 2 bits: current two's-complement symbol.
REQ-008 SHALL have port out_valid, output, 1 bit: out_sym is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts out_sym.
REQ-010 SHALL have port out_last, output, 1 bit: out_sym is symbol N-1 of the current word.
REQ-011 SHALL have port sym_err, output, 1 bit: sticky flag that an illegal symbol code was loaded.

Function
REQ-012 SHALL implement two states: IDLE (no word held) and SEND (word held, symbols pending).
REQ-013 SHALL count an input transfer when in_valid and in_ready are both 1 on a rising edge, and an output transfer when out_valid and out_ready are both 1.
REQ-014 SHALL drive in_ready = 1 in IDLE, and in SEND = out_ready AND (symbol index == N-1): a combinational path from out_ready that allows back-to-back words.
REQ-015 SHALL, on an input transfer, capture in_data into a 2N-bit shift register, set the symbol index to 0, and enter SEND.
REQ-016 SHALL assert out_valid in the cycle after an input transfer (latency 1), and hold it asserted throughout SEND.
REQ-017 SHALL emit symbols LSB pair first: out_sym = shift register bits [1:0], so pair 0 goes out first and pair N-1 last.
REQ-018 SHALL hold out_sym, out_last and the symbol index stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on an output transfer with index < N-1, shift the register right by 2 and increment the index.
REQ-020 SHALL, on an output transfer with index == N-1:
- with a simultaneous input transfer, load the new word and stay in SEND (no bubble);
- otherwise, enter IDLE with out_valid=0 on the next cycle.
REQ-021 SHALL drive out_last = out_valid AND (index == N-1); for N=1, every symbol is last.
REQ-022 SHALL size the index as max(1, clog2(N)) bits; the index never exceeds N-1.
REQ-023 SHALL set sym_err on an input transfer if any pair in in_data has bit 0 equal to 0 (codes 00 or 10); the word is still serialized unchanged.
REQ-024 SHALL clear sym_err only on reset.
REQ-025 SHALL ignore in_valid while in_ready=0 and hold no internal copy of a rejected word.
REQ-026 SHALL, in IDLE, drive out_sym to 2'b00.

Reset
REQ-027 SHALL, while rst_n=0, immediately force: state IDLE, out_valid=0, out_last=0, out_sym=2'b00, sym_err=0, index=0, shift register=0.
REQ-028 SHALL, on reset mid-word, discard the word with no further symbols; the first edge after release sees in_ready=1.

Structure
REQ-029 SHALL place the symbol constants SYM_POS=2'b01 and SYM_NEG=2'b11, the state encoding, and the N_MAX=15 constant in the shared modem package, for reuse by the modulator and demodulator.
REQ-030 SHALL be a single module with no sub-modules; the modulator instance stays external.

Verification
REQ-031 SHALL cover: N=8, in_data=16'hFFFD, out_ready=1 -> out_sym 01 then 11 x7, out_last only on the 8th, out_valid low the cycle after, sym_err=0.
REQ-032 SHALL cover back-to-back: two words 16'h5555 then 16'hFFFF, in_valid held -> 16 consecutive valid symbols (8x 01, 8x 11), no bubble, in_ready high exactly on the 8th transfer.
REQ-033 SHALL cover backpressure: out_ready low for 3 cycles at symbol index 2 -> out_sym and out_last are frozen, no symbol is lost or duplicated, and in_data changes are ignored.
REQ-034 SHALL cover an illegal code: in_data=16'h5554 (pair 0 = 00) -> sym_err=1 from the cycle after acceptance, first out_sym=00, and sym_err persists until rst_n=0.
REQ-035 SHALL cover reset mid-word: rst_n low at index 4 -> out_valid=0 immediately, and after release a new word starts at pair 0.
REQ-036 SHALL cover the extremes: N=15 with in_data=30'h3FFFFFFD -> 15 symbols, last on the 15th; and N=1 with in_data=2'b11 -> one symbol, out_last=1.
